// File: rtl/mc_core_bus.sv
// mc_core_bus -- multicycle MIPS-subset core on a single shared memory port.
//
// Executes addu, subu, slt, ori, lui, lw, sw, beq, j, jal.
// State sequence is FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// HALT is entered on a bus timeout and is left only through rst.
//
// Parameters:
//   RESET_PC : PC value loaded on reset
//   ADDR_W   : width of mem_addr (12..32)
//   TIMEOUT  : maximum wait cycles per bus transfer (0 = no timeout)
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   mem_req/mem_we      : bus request and store strobe
//   mem_addr/mem_wdata  : word-aligned byte address and store data
//   mem_rdata/mem_ack   : fetch/load data and transfer-complete handshake
//   illegal             : sticky flag, an unsupported instruction was decoded
//   bus_err             : sticky flag, a bus timeout halted the core
//   pc_o                : current PC
//
// Optional feature, macro DBG_WB_EN: adds wb_valid/wb_reg/wb_data, which
// pulse for the WB cycle of every GPR write that does not target $0.
module mc_core_bus #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          ADDR_W   = 32,
  parameter int          TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              illegal,
  output logic              bus_err,
  output logic [31:0]       pc_o
`ifdef DBG_WB_EN
  ,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data
`endif
);

  // Wait counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, ir_q, a_q, b_q, imm_q, alu_q, dr_q;
  logic [31:0]   rf_q [32];
  logic          illegal_q, bus_err_q;
  logic [CW-1:0] wait_q;

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] idx26;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign imm16 = ir_q[15:0];
  assign idx26 = ir_q[25:0];

  logic is_r, is_addu, is_subu, is_slt, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, valid;

  assign is_r    = (op == 6'h00);
  assign is_addu = is_r && (funct == 6'h21);
  assign is_subu = is_r && (funct == 6'h23);
  assign is_slt  = is_r && (funct == 6'h2A);
  assign is_ori  = (op == 6'h0D);
  assign is_lui  = (op == 6'h0F);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_j    = (op == 6'h02);
  assign is_jal  = (op == 6'h03);
  assign valid   = is_addu | is_subu | is_slt | is_ori | is_lui |
                   is_lw | is_sw | is_beq | is_j | is_jal;

  // ALU; the default (A + imm) is the lw/sw effective address.
  logic [31:0] alu_res;
  always_comb begin
    alu_res = a_q + imm_q;
    if (is_addu)      alu_res = a_q + b_q;
    else if (is_subu) alu_res = a_q - b_q;
    else if (is_slt)  alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
    else if (is_ori)  alu_res = a_q | imm_q;
    else if (is_lui)  alu_res = {imm16, 16'd0};
    else if (is_jal)  alu_res = pc_q;  // PC already points past the jal
  end

  // PC has been advanced in FETCH, so both targets are relative to PC+4.
  logic [31:0] br_tgt, jmp_tgt;
  assign br_tgt  = pc_q + {imm_q[29:0], 2'b00};
  assign jmp_tgt = {pc_q[31:28], idx26, 2'b00};

  // Write-back selection
  logic [4:0]  wb_sel;
  logic [31:0] wb_val;
  logic        wb_en;
  assign wb_sel = is_r ? rd : (is_jal ? 5'd31 : rt);
  assign wb_val = is_lw ? dr_q : alu_q;
  assign wb_en  = (state_q == S_WB) && (wb_sel != 5'd0);

  // A transfer is waiting when a request is out and no ack arrived.
  // Ack outside FETCH/MEM never matters because mem_req is low there.
  logic xfer_wait, timeout_hit;
  assign xfer_wait   = mem_req && !mem_ack;
  assign timeout_hit = (TIMEOUT > 0) && xfer_wait && (wait_q == CW'(TIMEOUT - 1));

  // Next state and bus outputs. Address/we/wdata come straight from
  // registers that do not change while a transfer waits.
  always_comb begin
    state_d   = state_q;
    mem_req   = !rst && ((state_q == S_FETCH) || (state_q == S_MEM));
    mem_we    = !rst && (state_q == S_MEM) && is_sw;
    mem_addr  = (state_q == S_MEM) ? {alu_q[ADDR_W-1:2], 2'b00}
                                   : {pc_q[ADDR_W-1:2], 2'b00};
    mem_wdata = b_q;
    case (state_q)
      S_FETCH:  if (timeout_hit) state_d = S_HALT;
                else if (mem_ack) state_d = S_DECODE;
      S_DECODE: state_d = valid ? S_EXEC : S_FETCH;
      S_EXEC:   if (is_beq || is_j)     state_d = S_FETCH;
                else if (is_lw || is_sw) state_d = S_MEM;
                else                     state_d = S_WB;
      S_MEM:    if (timeout_hit) state_d = S_HALT;
                else if (mem_ack) state_d = is_sw ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      dr_q      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= xfer_wait ? wait_q + 1'b1 : '0;
      if (timeout_hit) bus_err_q <= 1'b1;
      case (state_q)
        S_FETCH: if (mem_ack) begin
          ir_q <= mem_rdata;
          pc_q <= pc_q + 32'd4;
        end
        S_DECODE: begin
          a_q   <= rf_q[rs];
          b_q   <= rf_q[rt];
          imm_q <= is_ori ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};
          if (!valid) illegal_q <= 1'b1;
        end
        S_EXEC: begin
          alu_q <= alu_res;
          if (is_beq && (a_q == b_q)) pc_q <= br_tgt;
          else if (is_j || is_jal)    pc_q <= jmp_tgt;
        end
        S_MEM: if (mem_ack && is_lw) dr_q <= mem_rdata;
        S_WB:  if (wb_en) rf_q[wb_sel] <= wb_val;
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign pc_o    = pc_q;

`ifdef DBG_WB_EN
  assign wb_valid = wb_en;
  assign wb_reg   = wb_sel;
  assign wb_data  = wb_val;
`endif

endmodule

// File: tb/tb_mc_core_bus.sv
// Bench for mc_core_bus: table of single-ALU-instruction programs whose
// result is stored to memory, plus hand-written multi-cycle sequences.
module tb_mc_core_bus;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        illegal, bus_err;
  logic [31:0] pc_o;
`ifdef DBG_WB_EN
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
`endif

  mc_core_bus dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .illegal(illegal), .bus_err(bus_err), .pc_o(pc_o)
`ifdef DBG_WB_EN
    , .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0, nfail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {int c; logic [31:0] a; logic we; logic [31:0] d;} rq_t;
  rq_t         log_q[$];
  logic [31:0] mem [0:1023];
  logic [31:0] slow_addr, st_addr, st_data;
  int          slow_waits, cyc, wcnt, st_cnt, stab_err;
  bit          no_ack, spur_en, in_wait;

  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; wcnt = 0; in_wait = 0; mem_ack = 0;
    end else begin
      cyc++;
      if (mem_req) begin
        if (!in_wait) log_q.push_back(rq_t'{cyc, mem_addr, mem_we, mem_wdata});
        else if (log_q.size() > 0 && (log_q[$].a !== mem_addr || log_q[$].we !== mem_we ||
                 (mem_we && log_q[$].d !== mem_wdata)))
          stab_err++;
        if (no_ack || (mem_addr == slow_addr && wcnt < slow_waits)) begin
          mem_ack = 0; wcnt++; in_wait = 1;
        end else begin
          mem_ack = 1; wcnt = 0; in_wait = 0;
          mem_rdata = mem[mem_addr[11:2]];
          if (mem_we) begin st_cnt++; st_addr = mem_addr; st_data = mem_wdata; end
        end
      end else begin
        mem_ack = spur_en; wcnt = 0; in_wait = 0; mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // ---------------- encoders ----------------
  function automatic logic [31:0] R(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] I(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] J(input int op, input int idx);
    return {6'(op), 26'(idx)};
  endfunction

  localparam logic [31:0] LOOP = 32'h1000_FFFF;  // beq $0,$0,-1

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[11:2]] = w;
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    slow_addr = 32'hFFFF_FFFF; slow_waits = 0;
  endtask

  task automatic go(input bit chk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    if (chk) begin
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_we",  {31'd0, mem_we},  32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_bus_err", {31'd0, bus_err}, 32'd0);
      check("rst_pc",      pc_o,             32'h0000_3000);
    end
    log_q.delete(); st_cnt = 0; stab_err = 0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_store(input string nm, input int maxc);
    for (int i = 0; i < maxc && st_cnt == 0; i++) @(negedge clk);
    @(negedge clk);
    check({nm, "_store_seen"}, {31'd0, st_cnt > 0}, 32'd1);
  endtask

  task automatic chk_req(input string nm, input int k, input int ec, input logic [31:0] ea);
    if (k >= log_q.size()) begin
      ntests++; nfail++;
      $display("FAIL %s: request %0d missing, got %0d requests", nm, k, log_q.size());
    end else begin
      check({nm, "_cyc"},  32'(log_q[k].c), 32'(ec));
      check({nm, "_addr"}, log_q[k].a,      ea);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] a, b, instr;
    int          sreg;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int reqs, bad;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    no_ack = 0; spur_en = 0; st_cnt = 0; stab_err = 0;
    clear_mem();

    vecs[0] = '{"addu",      32'd5,          32'd7,          R(1,2,3,'h21), 3, 32'd12};
    vecs[1] = '{"addu_wrap", 32'hFFFF_FFFF,  32'd2,          R(1,2,3,'h21), 3, 32'd1};
    vecs[2] = '{"subu",      32'd5,          32'd7,          R(1,2,3,'h23), 3, 32'hFFFF_FFFE};
    vecs[3] = '{"slt_neg",   32'hFFFF_FFFF,  32'd1,          R(1,2,3,'h2A), 3, 32'd1};
    vecs[4] = '{"slt_pos",   32'd5,          32'h8000_0000,  R(1,2,3,'h2A), 3, 32'd0};
    vecs[5] = '{"slt_eq",    32'd7,          32'd7,          R(1,2,3,'h2A), 3, 32'd0};
    vecs[6] = '{"ori_zext",  32'h1234_0000,  32'd0,          I('h0D,1,3,16'h8001), 3, 32'h1234_8001};
    vecs[7] = '{"lui",       32'd0,          32'd0,          I('h0F,0,3,16'hABCD), 3, 32'hABCD_0000};
    vecs[8] = '{"addu_r0",   32'd5,          32'd5,          R(1,1,0,'h21), 0, 32'd0};

    go(1);

    // Table: load A/B via lui+ori, run the instruction, store the result.
    for (int i = 0; i < 9; i++) begin
      clear_mem();
      put(32'h3000, I('h0F,0,1,vecs[i].a[31:16]));
      put(32'h3004, I('h0D,1,1,vecs[i].a[15:0]));
      put(32'h3008, I('h0F,0,2,vecs[i].b[31:16]));
      put(32'h300C, I('h0D,2,2,vecs[i].b[15:0]));
      put(32'h3010, vecs[i].instr);
      put(32'h3014, I('h2B,0,vecs[i].sreg,16'h0200));
      put(32'h3018, LOOP);
      spur_en = (i % 2) == 1;  // stray acks between transfers must be ignored
      go(0);
      wait_store(vecs[i].name, 200);
      check({vecs[i].name, "_data"}, st_data, vecs[i].exp);
      check({vecs[i].name, "_addr"}, st_addr, 32'h0000_0200);
    end
    spur_en = 0;

    // ori then sw: fetch timing and value of $1
    clear_mem();
    put(32'h3000, I('h0D,0,1,16'h1234));
    put(32'h3004, I('h2B,0,1,16'h0200));
    put(32'h3008, LOOP);
    go(0);
    wait_store("ori", 100);
    chk_req("ori_f0", 0, 1, 32'h3000);
    chk_req("ori_f1", 1, 5, 32'h3004);
    chk_req("sw_mem", 2, 8, 32'h0200);
    chk_req("sw_next", 3, 9, 32'h3008);
    check("ori_val", st_data, 32'h0000_1234);

    // lw with two wait states, then unaligned sw
    clear_mem();
    put(32'h3000, I('h0D,0,1,16'h0100));
    put(32'h3004, I('h23,1,2,16'h0004));
    put(32'h3008, I('h2B,0,2,16'h0203));
    put(32'h300C, LOOP);
    put(32'h0104, 32'hDEAD_BEEF);
    slow_addr = 32'h0104; slow_waits = 2;
    go(0);
    wait_store("lw", 100);
    chk_req("lw_f", 1, 5, 32'h3004);
    chk_req("lw_mem", 2, 8, 32'h0104);
    chk_req("lw_next", 3, 12, 32'h3008);
    check("lw_stable", 32'(stab_err), 32'd0);
    check("lw_data", st_data, 32'hDEAD_BEEF);
    check("sw_align", st_addr, 32'h0000_0200);

    // beq not taken, then j back to 0x3000
    clear_mem();
    put(32'h3000, I('h0D,0,1,16'h0005));
    put(32'h3004, I('h04,0,1,16'h0002));
    put(32'h3008, J('h02,'h0C00));
    go(0);
    repeat (13) @(negedge clk);
    chk_req("beqnt", 2, 8, 32'h3008);
    chk_req("j_back", 3, 11, 32'h3000);

    // j forward, then beq-to-self
    clear_mem();
    put(32'h3000, J('h02,'h0C04));
    put(32'h3010, LOOP);
    go(0);
    repeat (9) @(negedge clk);
    chk_req("j_fwd", 1, 4, 32'h3010);
    chk_req("beq_self", 2, 7, 32'h3010);

    // jal link value
    clear_mem();
    put(32'h3000, J('h02,'h0C08));
    put(32'h3020, J('h03,'h0C0C));
    put(32'h3030, I('h2B,0,31,16'h0200));
    put(32'h3034, LOOP);
    go(0);
    wait_store("jal", 100);
    chk_req("jal_tgt", 2, 8, 32'h3030);
    check("jal_link", st_data, 32'h0000_3024);

    // unsupported funct: sticky flag, no write to rd, PC advances by 4
    clear_mem();
    put(32'h3000, {6'd0, 5'd2, 5'd2, 5'd1, 5'd0, 6'h3F});
    put(32'h3004, I('h2B,0,1,16'h0200));
    put(32'h3008, LOOP);
    go(0);
    @(negedge clk);
    check("ill_before", {31'd0, illegal}, 32'd0);
    wait_store("ill", 100);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    chk_req("ill_next", 1, 3, 32'h3004);
    check("ill_nowrite", st_data, 32'd0);

    // bus timeout: 16 wait cycles, then halted with mem_req low
    clear_mem();
    no_ack = 1;
    go(0);
    reqs = 0; bad = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k <= 16) begin
        if (mem_req) reqs++;
        if (bus_err) bad++;
      end else if (k == 17) begin
        check("to_bus_err", {31'd0, bus_err}, 32'd1);
        check("to_req_drop", {31'd0, mem_req}, 32'd0);
      end else if (mem_req || !bus_err) bad++;
    end
    check("to_req_cycles", 32'(reqs), 32'd16);
    check("to_halted", 32'(bad), 32'd0);
    no_ack = 0;
    go(0);
    check("to_cleared", {31'd0, bus_err}, 32'd0);

    // reset in the middle of a waiting load
    clear_mem();
    put(32'h3000, I('h0D,0,1,16'h0100));
    put(32'h3004, I('h23,1,2,16'h0004));
    put(32'h3008, LOOP);
    slow_addr = 32'h0104; slow_waits = 5;
    go(0);
    repeat (9) @(negedge clk);
    check("abort_pre_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort_pc", pc_o, 32'h0000_3000);

`ifdef DBG_WB_EN
    clear_mem();
    put(32'h3000, I('h0D,0,1,16'h0005));
    put(32'h3004, I('h0D,0,2,16'h0007));
    put(32'h3008, R(1,2,3,'h23));
    put(32'h300C, LOOP);
    go(0);
    reqs = 0; bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wb_valid && wb_reg == 5'd3) begin
        reqs++;
        if (wb_data !== 32'hFFFF_FFFE) bad++;
      end
    end
    check("dbg_pulses", 32'(reqs), 32'd1);
    check("dbg_data_bad", 32'(bad), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mc_core_bus.md
MC_CORE_BUS -- requirements
Module: mc_core_bus

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 32, width of mem_addr; range 12..32.
REQ-003 Parameter TIMEOUT, default 16, maximum wait cycles per bus transfer; 0 disables the timeout.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mem_req  output  1  bus request, held until the transfer completes.
REQ-007 mem_we  output  1  1 = store, 0 = fetch/load.
REQ-008 mem_addr  output  ADDR_W  word-aligned byte address; bits [1:0] always 0.
REQ-009 mem_wdata  output  32  store data.
REQ-010 mem_rdata  input  32  fetch/load data, valid in the cycle mem_ack=1.
REQ-011 mem_ack  input  1  transfer complete when mem_req&mem_ack in the same cycle.
REQ-012 illegal  output  1  sticky: unsupported instruction decoded.
REQ-013 bus_err  output  1  sticky: bus timeout occurred; core halted.
REQ-014 pc_o  output  32  current PC.

Function
REQ-015 The core SHALL execute MIPS encodings addu, subu, slt, ori, lui, lw, sw, beq, j, jal on one shared memory port, sequenced by an internal FSM: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on ack latch IR, PC<=PC+4 -> DECODE.
REQ-017 DECODE: read rs/rt into A/B, sign- or zero-extend imm16 per opcode -> EXEC.
REQ-018 EXEC: ALU result into ALUOUT; beq (A==B) sets PC<=PC+4+(sext(imm)<<2); j/jal set PC<={PC[31:28],idx26,2'b00}; beq/j -> FETCH, jal/R/ori/lui -> WB, lw/sw -> MEM.
REQ-019 MEM: mem_req=1, mem_addr=ALUOUT, mem_we=1 for sw with mem_wdata=B; on ack sw -> FETCH, lw latches DR -> WB.
REQ-020 WB: write rd (R-type), rt (ori/lui/lw) or $31 (jal, data = PC of jal +4) -> FETCH.
REQ-021 Latency with zero-wait ack: beq/j 3 cycles, R/ori/lui/jal/sw 4, lw 5; each wait cycle adds one.
REQ-022 mem_addr, mem_we, mem_wdata SHALL be stable while mem_req=1 and ack is not yet seen; mem_req SHALL drop the cycle after ack.
REQ-023 addu/subu wrap modulo 2^32; slt signed compare; no overflow traps.
REQ-024 Register $0 SHALL read 0; writes to $0 discarded.
REQ-025 Load/store address bits [1:0] SHALL be forced to 0; upper bits beyond ADDR_W truncated.
REQ-026 Unsupported opcode/funct: set illegal, no register/memory/PC-redirect effect, continue at FETCH.
REQ-027 TIMEOUT>0: if mem_req stays high TIMEOUT cycles without ack, drop mem_req, set bus_err -> HALT; HALT exits only on rst.
REQ-028 An ack arriving when mem_req=0 SHALL be ignored.

Reset
REQ-029 rst=1 SHALL set PC=RESET_PC, state FETCH, mem_req=0, mem_we=0, illegal=0, bus_err=0, all GPRs, IR, A, B, ALUOUT, DR to 0.
REQ-030 rst asserted mid-transfer SHALL abort it; mem_req=0 the following cycle and no register write occurs.

Configuration
REQ-031 With macro DBG_WB_EN defined: outputs wb_valid (1), wb_reg (5), wb_data (32) pulse for exactly the WB-state cycle of each non-$0 GPR write; undefined: ports absent, core behaviour identical.

Verification
REQ-032 Reset, zero-wait memory: first mem_addr=0x3000, ori $1,$0,0x1234 -> $1=0x0000_1234 after 4 cycles.
REQ-033 lw $2,4($1) with 2 wait states, mem_rdata=0xDEAD_BEEF -> $2=0xDEADBEEF at cycle 7, mem_addr stable during waits.
REQ-034 beq $0,$0,-1 at 0x3010 -> next fetch address 0x3010; j 0x0C00 -> next fetch 0x0000_3000.
REQ-035 jal at 0x3020 -> $31=0x3024; addu $0,$1,$1 -> $0 stays 0; funct 0x3F -> illegal=1, PC advances by 4.
REQ-036 TIMEOUT=16, ack never asserted -> bus_err=1 at 16th wait cycle, mem_req=0 thereafter until rst.
REQ-037 DBG_WB_EN defined, subu $3,$1,$2 with $1=5,$2=7 -> one-cycle wb_valid, wb_reg=3, wb_data=0xFFFF_FFFE.
